// File: rtl/gauss_pkg.sv
// ============================================================================
// gauss_pkg
// Shared types and constants for the Gaussian line scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gauss_pkg;

    // Position counter width (covers up to 511 pixels/lines)
    localparam int POS_W = 9;

    // Default geometry
    localparam int DEF_IMG_W  = 320;
    localparam int DEF_IMG_H  = 240;
    localparam int DEF_BORDER = 2;

    // Scheduler states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gauss_pos_cnt.sv
// ============================================================================
// gauss_pos_cnt
// Column/row position counter. Column wraps at IMG_W-1; row advances on each
// wrap unless hold_row is set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gauss_pos_cnt
    import gauss_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             beat,
    input  logic             hold_row,
    output logic [POS_W-1:0] col,
    output logic [POS_W-1:0] row
);

    localparam logic [POS_W-1:0] COL_LAST = POS_W'(IMG_W - 1);

    // Advance position on every beat; clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (beat) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (!hold_row)
                    row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gauss_line_sched.sv
// ============================================================================
// gauss_line_sched
// Frame scheduler for a line-buffered Gaussian filter: primes one line,
// streams the body, then flushes the final output line.
// Optional macro GAUSS_SCHED_ERR_EN enables the sticky protocol-error flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gauss_line_sched
    import gauss_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int BORDER = DEF_BORDER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             flt_en,
    output logic             out_valid,
    output logic             zero_pix,
    output logic [POS_W-1:0] col,
    output logic [POS_W-1:0] row,
    output logic             row_update,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam logic [POS_W-1:0] COL_LAST = POS_W'(IMG_W - 1);
    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(IMG_H - 1);
    localparam logic [POS_W-1:0] B_LO     = POS_W'(BORDER);
    localparam logic [POS_W-1:0] COL_HI   = POS_W'(IMG_W - BORDER);
    localparam logic [POS_W-1:0] ROW_HI   = POS_W'(IMG_H - BORDER);

    state_t           state;
    logic             beat;
    logic             line_end;
    logic             last_line;
    logic             clr;
    logic             hold_row;
    logic [POS_W-1:0] out_row;

    gauss_pos_cnt #(
        .IMG_W (IMG_W)
    ) u_pos_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .beat     (beat),
        .hold_row (hold_row),
        .col      (col),
        .row      (row)
    );

    assign line_end  = (col == COL_LAST);
    assign last_line = (row == ROW_LAST);
    assign clr       = (state == S_IDLE) && frame_start;
    // Row freezes on the last input line so FLUSH sees IMG_H-1
    assign hold_row  = (state == S_FLUSH) || last_line;

    // Handshake decode from registered state and live handshake inputs
    always_comb begin
        in_ready  = 1'b0;
        beat      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_PRIME: begin
                in_ready = 1'b1;
                beat     = in_valid;
            end
            S_RUN: begin
                in_ready  = out_ready;
                beat      = in_valid && out_ready;
                out_valid = in_valid && out_ready;
            end
            S_FLUSH: begin
                beat      = out_ready;
                out_valid = out_ready;
            end
            default: ;
        endcase
        if (rst) begin
            in_ready  = 1'b0;
            beat      = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign flt_en = beat;

    // Output lags input by one line except in FLUSH, where it is the last line
    assign out_row  = (state == S_FLUSH) ? ROW_LAST : (row - 1'b1);
    assign zero_pix = out_valid &&
                      ((col < B_LO) || (col >= COL_HI) ||
                       (out_row < B_LO) || (out_row >= ROW_HI));

    assign busy       = (state == S_PRIME) || (state == S_RUN) || (state == S_FLUSH);
    assign frame_done = (state == S_DONE);

    // Frame sequencing and end-of-input-line strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row_update <= 1'b0;
        end else begin
            row_update <= beat && line_end && ((state == S_PRIME) || (state == S_RUN));
            case (state)
                S_IDLE:  if (frame_start)                      state <= S_PRIME;
                S_PRIME: if (beat && line_end)                 state <= S_RUN;
                S_RUN:   if (beat && line_end && last_line)    state <= S_FLUSH;
                S_FLUSH: if (beat && line_end)                 state <= S_DONE;
                S_DONE:                                        state <= S_IDLE;
                default:                                       state <= S_IDLE;
            endcase
        end
    end

`ifdef GAUSS_SCHED_ERR_EN
    // Sticky protocol error: restart while busy, or pixel offered while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((frame_start && busy) || (in_valid && (state == S_IDLE)))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire
